// File: rtl/decode_prefetch_queue.sv
// decode_prefetch_queue: byte prefetch FIFO that assembles 1-3 byte instructions tagged with their PC.
module decode_prefetch_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [7:0]      in_data,
  output logic            in_ready,
  input  logic            flush,
  input  logic [PC_W-1:0] flush_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [7:0]      inst_opcode,
  output logic [7:0]      inst_op1,
  output logic [7:0]      inst_op2,
  output logic [1:0]      inst_len,
  output logic [PC_W-1:0] inst_pc,
  output logic [LW-1:0]   level
);
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wp_q, wp_d, rp_q, rp_d;
  logic [LW-1:0]   level_q, level_d;
  logic            valid_q, valid_d;
  logic [7:0]      op_q, op_d, op1_q, op1_d, op2_q, op2_d;
  logic [1:0]      len_q, len_d, hlen;
  logic [PC_W-1:0] pc_q, pc_d, next_pc_q, next_pc_d;
  logic [7:0]      h0, h1, h2;
  logic            push, issue, len1, len3;
  assign h0 = mem_q[rp_q];
  assign h1 = mem_q[rp_q + AW'(1)];
  assign h2 = mem_q[rp_q + AW'(2)];
  assign len1 = h0 == 8'h00 || h0 == 8'h40 || h0 == 8'h60 || (h0[3:2] == 2'b10 && !h0[0]);
  assign len3 = h0 == 8'h20 || h0[4:2] == 3'b011 || h0[4:3] == 2'b11;
  assign hlen = len1 ? 2'd1 : len3 ? 2'd3 : 2'd2;
  assign in_ready = level_q < LW'(DEPTH) && !flush;
  assign push = in_valid && in_ready;
  // head bytes only count once registered, so a byte never issues in its own push cycle
  assign issue = level_q >= LW'(hlen) && (!valid_q || inst_ready) && !flush;
  always_comb begin
    wp_d = wp_q;
    rp_d = rp_q;
    level_d = level_q;
    valid_d = valid_q;
    op_d = op_q;
    op1_d = op1_q;
    op2_d = op2_q;
    len_d = len_q;
    pc_d = pc_q;
    next_pc_d = next_pc_q;
    if (flush) begin
      wp_d = '0;
      rp_d = '0;
      level_d = '0;
      valid_d = 1'b0;
      next_pc_d = flush_pc;
    end else begin
      wp_d = push ? wp_q + AW'(1) : wp_q;
      level_d = level_q + LW'(push) - (issue ? LW'(hlen) : LW'(0));
      if (issue) begin
        rp_d = rp_q + AW'(hlen);
        valid_d = 1'b1;
        op_d = h0;
        op1_d = hlen >= 2'd2 ? h1 : 8'h00;
        op2_d = hlen == 2'd3 ? h2 : 8'h00;
        len_d = hlen;
        pc_d = next_pc_q;
        next_pc_d = next_pc_q + PC_W'(hlen);
      end else if (inst_ready) begin
        valid_d = 1'b0;
      end
    end
  end
  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= in_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
      op_q <= '0;
      op1_q <= '0;
      op2_q <= '0;
      len_q <= 2'd1;
      pc_q <= RESET_PC;
      next_pc_q <= RESET_PC;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      level_q <= level_d;
      valid_q <= valid_d;
      op_q <= op_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
      len_q <= len_d;
      pc_q <= pc_d;
      next_pc_q <= next_pc_d;
    end
  end
  assign inst_valid = valid_q;
  assign inst_opcode = op_q;
  assign inst_op1 = op1_q;
  assign inst_op2 = op2_q;
  assign inst_len = len_q;
  assign inst_pc = pc_q;
  assign level = level_q;
endmodule
